// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// UART receive stage. RXD is synchronised, then sampled with the x32
// oversample tick. Each bit is decided by a 3-sample majority vote taken on
// tick counts 15/16/17. Frames are start + DATA_BITS (LSB first)
// [+ parity] + stop. Received bytes are offered on a registered valid/ready
// output. One-cycle pulses flag framing errors and overruns.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits, and a PARITY_ERR output registered alongside DATA_OUT.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   TICK_X32   one-cycle pulse, 32 per bit period
//   RXD        asynchronous serial input, idle high
//   DATA_OUT   received byte, stable while DATA_VALID=1
//   DATA_VALID DATA_OUT holds an unconsumed byte
//   DATA_READY consumer accepts when DATA_VALID & DATA_READY at a CLK edge
//   FRAME_ERR  one-cycle pulse: stop bit sampled 0
//   OVERRUN    one-cycle pulse: completed byte dropped, output still full
//   PARITY_ERR (UART_RX_PARITY_EN only) parity mismatch for DATA_OUT
//   BUSY       receiver not idle
module uart_rx_oversample #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TICK_X32,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
`ifdef UART_RX_PARITY_EN
  output logic                 PARITY_ERR,
`endif
  output logic                 BUSY
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || SYNC_STAGES < 2 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_oversample: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             smp_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tick17_c;
  logic                   tick31_c;
  logic                   maj_c;
  logic                   shift_en_c;
  logic                   deliver_c;
  logic                   frame_err_c;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   par_cap_c;
`endif

  // RXD synchroniser, idles high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Count 17 decides the bit (samples 15 and 16 stored, 17 is live rxs)
  assign tick17_c = TICK_X32 && (cnt_q == CNT_W'(17));
  assign tick31_c = TICK_X32 && (cnt_q == CNT_W'(31));
  assign maj_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (tick17_c && maj_c) state_d = S_IDLE;
        else if (tick31_c)     state_d = S_DATA;
      end
      S_DATA: begin
        if (tick31_c && (idx_q == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick31_c) state_d = S_STOP;
      end
`endif
      // Stop is decided mid-bit so the next start edge can be caught
      S_STOP: begin
        if (tick17_c) state_d = maj_c ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state actions
  always_comb begin
    shift_en_c  = 1'b0;
    deliver_c   = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap_c   = 1'b0;
`endif
    case (state_q)
      S_DATA: shift_en_c = tick17_c;
`ifdef UART_RX_PARITY_EN
      S_PARITY: par_cap_c = tick17_c;
`endif
      S_STOP: begin
        deliver_c   = tick17_c & maj_c;
        frame_err_c = tick17_c & ~maj_c;
      end
      default: ;
    endcase
  end

  // Tick counter, samples, bit index and shift register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      smp_q   <= '1;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_d != state_q) cnt_q <= '0;
      else if (TICK_X32)      cnt_q <= cnt_q + CNT_W'(1);

      if (TICK_X32 && (cnt_q == CNT_W'(15))) smp_q[0] <= rxs;
      if (TICK_X32 && (cnt_q == CNT_W'(16))) smp_q[1] <= rxs;

      if ((state_d == S_DATA) && (state_q != S_DATA)) idx_q <= '0;
      else if ((state_q == S_DATA) && tick31_c)      idx_q <= idx_q + IDX_W'(1);

      // LSB first: shift in at the top, first bit ends in bit 0
      if (shift_en_c) shift_q <= {maj_c, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            par_q <= 1'b0;
    else if (par_cap_c) par_q <= maj_c;
  end
`endif

  // Output holding register and status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
      BUSY       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
    end else begin
      FRAME_ERR <= frame_err_c;
      OVERRUN   <= 1'b0;
      BUSY      <= (state_d != S_IDLE);
      if (deliver_c) begin
        // A same-cycle consume frees the slot for the new byte
        if (!DATA_VALID || DATA_READY) begin
          DATA_OUT   <= shift_q;
          DATA_VALID <= 1'b1;
`ifdef UART_RX_PARITY_EN
          PARITY_ERR <= (^shift_q) ^ par_q ^ 1'(PARITY_ODD);
`endif
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (DATA_VALID && DATA_READY) begin
        DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Testbench for uart_rx_oversample: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_oversample;

  localparam int BIT_CYC = 128;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int NBITS    = PAR_ON ? 11 : 10;
  localparam bit PODD     = 1'b0;
  // Start seen 3 edges after the line falls; stop decided on tick 18 of the last bit
  localparam int BUSY_OK  = (NBITS - 1) * BIT_CYC + 72 - 3;
  // Bad stop: busy until the line returns high one bit after the stop bit starts
  localparam int BUSY_FE  = NBITS * BIT_CYC;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK_X32;
  logic       RXD;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERR;
`endif

  uart_rx_oversample #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .PARITY_ODD (0)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TICK_X32  (TICK_X32),
    .RXD       (RXD),
    .DATA_OUT  (DATA_OUT),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR(PARITY_ERR),
`endif
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Oversample tick: one cycle in four
  initial begin
    int ph;
    ph = 0;
    TICK_X32 = 1'b0;
    forever begin
      @(negedge CLK);
      ph = (ph + 1) % 4;
      TICK_X32 = (ph == 0);
    end
  end

  int checks = 0;
  int errors = 0;
  int valid_cycles, fe_cnt, ov_cnt, busy_cnt, both_cnt;
  int xfer_q[$];

  // Monitor: samples mid-cycle, after outputs and inputs have settled
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (DATA_VALID) valid_cycles++;
      if (FRAME_ERR) fe_cnt++;
      if (OVERRUN) ov_cnt++;
      if (BUSY) busy_cnt++;
      if (FRAME_ERR && OVERRUN) both_cnt++;
      if (DATA_VALID && DATA_READY) begin
`ifdef UART_RX_PARITY_EN
        xfer_q.push_back(int'(DATA_OUT) | (int'(PARITY_ERR) << 8));
`else
        xfer_q.push_back(int'(DATA_OUT));
`endif
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cycles = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
    busy_cnt     = 0;
    both_cnt     = 0;
    xfer_q.delete();
  endtask

  task automatic send_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      RXD = 1'b1;
    end
  endtask

  // Drives ncyc cycles of a frame aligned to a tick; glitch inverts each
  // data bit for the 4 cycles that reach the count-16 sample
  task automatic send_frame(input logic [7:0] data, input logic stop, input bit glitch,
                            input bit bad_par, input int ncyc);
    logic [10:0] bits;
    logic        par;
    logic        v;
    par  = (^data) ^ PODD ^ bad_par;
    bits = {stop, (PAR_ON ? par : stop), data, 1'b0};
    do @(posedge CLK); while (!TICK_X32);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      v = bits[c / BIT_CYC];
      if (glitch && (c / BIT_CYC) >= 1 && (c / BIT_CYC) <= 8 &&
          (c % BIT_CYC) >= 65 && (c % BIT_CYC) < 69) v = ~v;
      RXD = v;
    end
  endtask

  task automatic check_frame(input string tag, input int exp_n, input int exp_data,
                             input int exp_fe, input int exp_busy);
    check({tag, "_xfers"}, xfer_q.size(), exp_n);
    check({tag, "_valid_cycles"}, valid_cycles, exp_n);
    if (exp_n > 0 && xfer_q.size() > 0) check({tag, "_data"}, xfer_q[0], exp_data);
    check({tag, "_frame_err"}, fe_cnt, exp_fe);
    check({tag, "_overrun"}, ov_cnt, 0);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_fe_ov_together"}, both_cnt, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         glitch;
    int         exp_n;
    int         exp_data;
    int         exp_fe;
    int         exp_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] d;
    logic       st;
    bit         gl;
    int         en, efe, eb;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1, 'hA5, 0, BUSY_OK};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 'h00, 0, BUSY_OK};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 1, 'hFF, 0, BUSY_OK};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1, 'h01, 0, BUSY_OK};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1, 'h80, 0, BUSY_OK};
    tbl[5] = '{8'h55, 1'b0, 1'b0, 0, 0,    1, BUSY_FE};
    tbl[6] = '{8'h12, 1'b1, 1'b0, 1, 'h12, 0, BUSY_OK};

    RST        = 1'b1;
    RXD        = 1'b1;
    DATA_READY = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    check("rst_data_out", int'(DATA_OUT), 0);
    check("rst_data_valid", int'(DATA_VALID), 0);
    check("rst_frame_err", int'(FRAME_ERR), 0);
    check("rst_overrun", int'(OVERRUN), 0);
    check("rst_busy", int'(BUSY), 0);
    @(negedge CLK);
    RST = 1'b0;
    send_idle(40);

    // Table-driven frames with the consumer always ready
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].glitch, 1'b0, NBITS * BIT_CYC);
      send_idle(64);
      check_frame($sformatf("tbl%0d", i), tbl[i].exp_n, tbl[i].exp_data,
                  tbl[i].exp_fe, tbl[i].exp_busy);
    end

    // Overrun: two back-to-back bytes with the consumer stalled
    clear_mon();
    @(negedge CLK);
    DATA_READY = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, NBITS * BIT_CYC);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, NBITS * BIT_CYC);
    send_idle(64);
    #1;
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_valid_held", int'(DATA_VALID), 1);
    check("ovr_data_kept", int'(DATA_OUT), 'h3C);
    check("ovr_frame_err", fe_cnt, 0);
    check("ovr_no_xfer", xfer_q.size(), 0);
    @(negedge CLK);
    DATA_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("ovr_valid_drop", int'(DATA_VALID), 0);
    check("ovr_xfer_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("ovr_xfer_data", xfer_q[0], 'h3C);
    send_idle(16);

    // Bad stop bit followed by a held-low line
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, NBITS * BIT_CYC);
    for (int c = 0; c < 20 * BIT_CYC; c++) begin
      @(negedge CLK);
      RXD = 1'b0;
    end
    #1;
    check("brk_busy_held", int'(BUSY), 1);
    check("brk_fe_once", fe_cnt, 1);
    check("brk_no_valid", valid_cycles, 0);
    send_idle(8);
    #1;
    check("brk_busy_release", int'(BUSY), 0);
    check("brk_fe_still_once", fe_cnt, 1);
    check("brk_overrun", ov_cnt, 0);
    send_idle(64);
    clear_mon();
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, NBITS * BIT_CYC);
    send_idle(64);
    check_frame("brk_next", 1, 'h12, 0, BUSY_OK);

    // 8-tick low glitch while idle: false start at count 17
    clear_mon();
    do @(posedge CLK); while (!TICK_X32);
    for (int c = 0; c < 32; c++) begin
      @(negedge CLK);
      RXD = 1'b0;
    end
    send_idle(100);
    #1;
    check("fs_busy_cycles", busy_cnt, 72 - 3);
    check("fs_busy_now", int'(BUSY), 0);
    check("fs_frame_err", fe_cnt, 0);
    check("fs_overrun", ov_cnt, 0);
    check("fs_valid", valid_cycles, 0);

    // Reset in the middle of a frame while a byte is pending
    @(negedge CLK);
    DATA_READY = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, NBITS * BIT_CYC);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 600);
    #1;
    check("rmid_busy_before", int'(BUSY), 1);
    check("rmid_valid_before", int'(DATA_VALID), 1);
    RST = 1'b1;
    #1;
    check("rmid_data_out", int'(DATA_OUT), 0);
    check("rmid_data_valid", int'(DATA_VALID), 0);
    check("rmid_busy", int'(BUSY), 0);
    check("rmid_frame_err", int'(FRAME_ERR), 0);
    check("rmid_overrun", int'(OVERRUN), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    DATA_READY = 1'b1;
    send_idle(40);
    clear_mon();
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, NBITS * BIT_CYC);
    send_idle(64);
    check_frame("rmid_next", 1, 'h0F, 0, BUSY_OK);

    // Randomized frames: good stop delivers the byte, bad stop flags it
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      gl = 1'($urandom_range(0, 1));
      en  = st ? 1 : 0;
      efe = st ? 0 : 1;
      eb  = st ? BUSY_OK : BUSY_FE;
      clear_mon();
      send_frame(d, st, gl, 1'b0, NBITS * BIT_CYC);
      send_idle(16 + int'($urandom_range(0, 100)));
      check_frame($sformatf("rnd%0d_d%02h_s%0d", k, d, st), en, int'(d), efe, eb);
    end

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte still delivered with PARITY_ERR set
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, NBITS * BIT_CYC);
    send_idle(64);
    check_frame("par_bad", 1, 'h107, 0, BUSY_OK);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
